// File: rtl/cosmac_bus_responder_if.sv
// ----------------------------------------------------------------------------
// cosmac_bus_responder_if
// Bundles the CDP1802 pin-side signals and the on-chip backend port of the
// COSMAC bus responder.
//   slave  : the responder (samples CPU pins, drives data bus, issues requests)
//   master : the environment (CPU pins + backend memory model)
// Signals:
//   tpa, tpb, nmrd, nmwr, ma[7:0], db_in[7:0]  CPU -> responder (asynchronous)
//   db_out[7:0], db_oe, nwait                  responder -> CPU pads
//   mem_addr[15:0], mem_wdata[7:0], mem_req,
//   mem_we                                     responder -> backend
//   mem_ready, mem_rdata[7:0]                  backend -> responder
//   bus_err                                    protocol-violation pulse
// ----------------------------------------------------------------------------
interface cosmac_bus_responder_if;
   logic        tpa;
   logic        tpb;
   logic        nmrd;
   logic        nmwr;
   logic [7:0]  ma;
   logic [7:0]  db_in;
   logic [7:0]  db_out;
   logic        db_oe;
   logic        nwait;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_req;
   logic        mem_we;
   logic        mem_ready;
   logic [7:0]  mem_rdata;
   logic        bus_err;

   modport slave (
      input  tpa, tpb, nmrd, nmwr, ma, db_in, mem_ready, mem_rdata,
      output db_out, db_oe, nwait, mem_addr, mem_wdata, mem_req, mem_we, bus_err
   );

   modport master (
      output tpa, tpb, nmrd, nmwr, ma, db_in, mem_ready, mem_rdata,
      input  db_out, db_oe, nwait, mem_addr, mem_wdata, mem_req, mem_we, bus_err
   );
endinterface

// File: rtl/cosmac_bus_responder.sv
// ----------------------------------------------------------------------------
// cosmac_bus_responder
// Memory-side end of the CDP1802 external bus. Latches the high address byte
// on the falling edge of TPA, takes the low byte from MA after the strobe
// settles, runs MRD reads / MWR writes against a req/ready backend, and drives
// the shared data bus and nWAIT.
// Ports:
//   clk_16mhz  system clock, rising edge
//   reset      synchronous active-high reset
//   bus        cosmac_bus_responder_if.slave (CPU pins + backend port)
// Parameters:
//   SYNC_STAGES  synchronizer depth on all CPU-side inputs (>= 2)
//   SETTLE       extra cycles after a detected strobe fall before MA is sampled
// Build option:
//   COSMEM_NWAIT_EN  when defined, nwait is held low from read request until
//                    read data is driven; otherwise nwait stays high.
// ----------------------------------------------------------------------------
module cosmac_bus_responder #(
   parameter int SYNC_STAGES = 2,
   parameter int SETTLE      = 1
) (
   input  logic                  clk_16mhz,
   input  logic                  reset,
   cosmac_bus_responder_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE, ADDR, RD_SETTLE, RD_WAIT, RD_DRIVE, WR_SETTLE, WR_HOLD, WR_WAIT
   } state_t;

   localparam logic [7:0] SETTLE_C = 8'(SETTLE);
   // Idle levels of {tpa, nmrd, nmwr}
   localparam logic [2:0] CTL_IDLE = 3'b011;

`ifdef COSMEM_NWAIT_EN
   localparam logic NWAIT_RD = 1'b0;
`else
   localparam logic NWAIT_RD = 1'b1;
`endif

   // ctl_q[SYNC_STAGES-1] is the synchronized value; the extra top stage holds
   // the previous synchronized value for edge detection.
   logic [SYNC_STAGES:0][2:0]    ctl_q;
   logic [SYNC_STAGES-1:0][15:0] dat_q;

   logic       tpa_s, nmrd_s, nmwr_s, tpa_p_s, nmrd_p_s, nmwr_p_s;
   logic       tpa_fall_s, rd_fall_s, rd_rise_s, wr_fall_s, wr_rise_s, both_new_s;
   logic [7:0] ma_s, db_s;
   logic       busy_wait_s;
   logic       unused_s;

   state_t      state_q;
   logic [7:0]  addr_hi_q;
   logic [7:0]  cnt_q;
   logic [7:0]  wbuf_q;
   logic        abort_q;
   logic [7:0]  db_out_q;
   logic        db_oe_q;
   logic        nwait_q;
   logic [15:0] mem_addr_q;
   logic [7:0]  mem_wdata_q;
   logic        mem_req_q;
   logic        mem_we_q;
   logic        bus_err_q;

   // Input synchronizers; MA and DB share the strobe depth so they stay aligned.
   always_ff @(posedge clk_16mhz) begin
      if (reset) begin
         ctl_q <= {(SYNC_STAGES + 1){CTL_IDLE}};
         dat_q <= '0;
      end else begin
         ctl_q <= {ctl_q[SYNC_STAGES-1:0], {bus.tpa, bus.nmrd, bus.nmwr}};
         dat_q <= {dat_q[SYNC_STAGES-2:0], {bus.ma, bus.db_in}};
      end
   end

   assign {tpa_s, nmrd_s, nmwr_s}       = ctl_q[SYNC_STAGES-1];
   assign {tpa_p_s, nmrd_p_s, nmwr_p_s} = ctl_q[SYNC_STAGES];
   assign {ma_s, db_s}                  = dat_q[SYNC_STAGES-1];

   assign tpa_fall_s  = tpa_p_s & ~tpa_s;
   assign rd_fall_s   = nmrd_p_s & ~nmrd_s;
   assign rd_rise_s   = ~nmrd_p_s & nmrd_s;
   assign wr_fall_s   = nmwr_p_s & ~nmwr_s;
   assign wr_rise_s   = ~nmwr_p_s & nmwr_s;
   // Only the first cycle of an overlap raises bus_err, so it is a single pulse.
   assign both_new_s  = (~nmrd_s & ~nmwr_s) & ~(~nmrd_p_s & ~nmwr_p_s);
   // A pending backend access must run to mem_ready regardless of the CPU pins.
   assign busy_wait_s = (state_q == RD_WAIT) || (state_q == WR_WAIT);
   assign unused_s    = bus.tpb;

   // Transaction FSM with registered bus and backend outputs.
   always_ff @(posedge clk_16mhz) begin
      if (reset) begin
         state_q     <= IDLE;
         addr_hi_q   <= 8'h00;
         cnt_q       <= 8'h00;
         wbuf_q      <= 8'h00;
         abort_q     <= 1'b0;
         db_out_q    <= 8'h00;
         db_oe_q     <= 1'b0;
         nwait_q     <= 1'b1;
         mem_addr_q  <= 16'h0000;
         mem_wdata_q <= 8'h00;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         bus_err_q   <= 1'b0;
      end else begin
         bus_err_q <= 1'b0;
         // Last data sampled while MWR is low is what gets written.
         if (!nmwr_s) begin
            wbuf_q <= db_s;
         end
         if (both_new_s && !busy_wait_s) begin
            bus_err_q <= 1'b1;
            db_oe_q   <= 1'b0;
            state_q   <= IDLE;
         end else if (tpa_fall_s && !busy_wait_s) begin
            addr_hi_q <= ma_s;
            db_oe_q   <= 1'b0;
            state_q   <= ADDR;
         end else begin
            case (state_q)
               IDLE, ADDR: begin
                  cnt_q <= 8'h00;
                  // A strobe without a preceding TPA targets page 0x00.
                  if ((state_q == IDLE) && (rd_fall_s || wr_fall_s)) begin
                     addr_hi_q <= 8'h00;
                  end
                  if (rd_fall_s) begin
                     state_q <= RD_SETTLE;
                  end else if (wr_fall_s) begin
                     state_q <= WR_SETTLE;
                  end
               end
               RD_SETTLE: begin
                  if (rd_rise_s) begin
                     state_q <= IDLE;
                  end else if (cnt_q >= SETTLE_C) begin
                     mem_addr_q <= {addr_hi_q, ma_s};
                     mem_req_q  <= 1'b1;
                     mem_we_q   <= 1'b0;
                     abort_q    <= 1'b0;
                     nwait_q    <= NWAIT_RD;
                     state_q    <= RD_WAIT;
                  end else begin
                     cnt_q <= cnt_q + 8'd1;
                  end
               end
               RD_WAIT: begin
                  if (rd_rise_s) begin
                     abort_q <= 1'b1;
                  end
                  if (bus.mem_ready) begin
                     mem_req_q <= 1'b0;
                     nwait_q   <= 1'b1;
                     if (abort_q || rd_rise_s) begin
                        state_q <= IDLE;
                     end else begin
                        db_out_q <= bus.mem_rdata;
                        db_oe_q  <= 1'b1;
                        state_q  <= RD_DRIVE;
                     end
                  end
               end
               RD_DRIVE: begin
                  if (rd_rise_s) begin
                     db_oe_q <= 1'b0;
                     state_q <= IDLE;
                  end
               end
               WR_SETTLE: begin
                  if (wr_rise_s) begin
                     state_q <= IDLE;
                  end else if (cnt_q >= SETTLE_C) begin
                     mem_addr_q <= {addr_hi_q, ma_s};
                     state_q    <= WR_HOLD;
                  end else begin
                     cnt_q <= cnt_q + 8'd1;
                  end
               end
               WR_HOLD: begin
                  if (wr_rise_s) begin
                     mem_req_q   <= 1'b1;
                     mem_we_q    <= 1'b1;
                     mem_wdata_q <= wbuf_q;
                     state_q     <= WR_WAIT;
                  end
               end
               WR_WAIT: begin
                  if (bus.mem_ready) begin
                     mem_req_q <= 1'b0;
                     mem_we_q  <= 1'b0;
                     state_q   <= IDLE;
                  end
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign bus.db_out    = db_out_q;
   assign bus.db_oe     = db_oe_q;
   assign bus.nwait     = nwait_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.bus_err   = bus_err_q;

endmodule
